autosym_dred_eval: RTL

Pipelined, runtime-programmable evaluator for autosymmetric Boolean functions in D-reduced form. Each output is f(x) = f_r(λ(x)), where λ is an XOR-linear projection of the N_IN inputs onto N_RED reduced variables and f_r is a 2^N_RED-entry truth table. It supersedes the fixed single-output, 8-input combinational benchmark netlists. Any reduced function is loaded through a configuration port and then evaluated at one vector per cycle behind valid/ready handshakes.

---
 rtl/autosym_dred_eval.sv | 99 +++++++++
 1 files changed

// File: rtl/autosym_dred_eval.sv
// autosym_dred_eval: two-stage evaluator f(x) = f_r(lambda(x)) with a runtime-loaded XOR projection and truth tables.
// Define AUTOSYM_DRED_EVAL_STATS_EN to add the saturating eval_count handshake counter.
module autosym_dred_eval #(
    parameter int N_IN  = 8,
    parameter int N_RED = 4,
    parameter int N_OUT = 1,
    localparam int TB   = N_OUT * (1 << N_RED),
    localparam int AW   = $clog2(TB)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_req,
    input  logic             cfg_commit,
    input  logic             cfg_we,
    input  logic             cfg_sel,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [N_IN-1:0]  cfg_wdata,
    output logic             cfg_ready,
    output logic             cfg_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_y
`ifdef AUTOSYM_DRED_EVAL_STATS_EN
    ,output logic [15:0]     eval_count
`endif
);
    typedef enum logic [1:0] {S_CFG, S_RUN, S_DRAIN} state_t;
    state_t                 r_state, w_next;
    logic [N_IN-1:0]        r_row [N_RED];
    logic [(1<<N_RED)-1:0]  r_tab [N_OUT];
    logic                   r_s1_valid, r_s2_valid, r_err;
    logic [N_RED-1:0]       r_lam, w_lam;
    logic [N_OUT-1:0]       r_y, w_y;
    logic                   w_s1_adv, w_s2_adv, w_acc;
    assign w_s2_adv  = !r_s2_valid | out_ready;
    assign w_s1_adv  = !r_s1_valid | w_s2_adv;
    assign in_ready  = (r_state == S_RUN) & w_s1_adv;
    assign w_acc     = in_valid & in_ready;
    assign cfg_ready = r_state == S_CFG;
    assign cfg_err   = r_err;
    assign out_valid = r_s2_valid;
    assign out_y     = r_y;
    always_comb begin
        w_next = r_state == S_CFG ? (cfg_commit ? S_RUN : S_CFG)
               : r_state == S_RUN ? (cfg_req ? S_DRAIN : S_RUN)
               : (!r_s1_valid && !r_s2_valid ? S_CFG : S_DRAIN);
    end
    always_comb begin
        w_lam = '0;
        for (int r = 0; r < N_RED; r++) w_lam[r] = ^(in_x & r_row[r]);
    end
    always_comb begin
        w_y = '0;
        for (int o = 0; o < N_OUT; o++) w_y[o] = r_tab[o][r_lam];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_CFG;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_lam      <= '0;
            r_y        <= '0;
            r_err      <= 1'b0;
            for (int r = 0; r < N_RED; r++) r_row[r] <= '0;
            for (int o = 0; o < N_OUT; o++) r_tab[o] <= '0;
        end else begin
            r_state <= w_next;
            if (w_s1_adv) begin
                r_s1_valid <= w_acc;
                r_lam      <= w_lam;
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                r_y        <= w_y;
            end
            if (cfg_we) begin
                if (r_state != S_CFG || (!cfg_sel && int'(cfg_addr) >= N_RED)) r_err <= 1'b1;
                if (r_state == S_CFG && !cfg_sel)
                    for (int r = 0; r < N_RED; r++)
                        if (int'(cfg_addr) == r) r_row[r] <= cfg_wdata;
                // table bit address is output-major: o*2^N_RED + lambda
                if (r_state == S_CFG && cfg_sel)
                    for (int o = 0; o < N_OUT; o++)
                        if ((int'(cfg_addr) >> N_RED) == o) r_tab[o][cfg_addr[N_RED-1:0]] <= cfg_wdata[0];
            end
        end
    end
`ifdef AUTOSYM_DRED_EVAL_STATS_EN
    logic [15:0] r_cnt;
    assign eval_count = r_cnt;
    always_ff @(posedge clk) begin
        if (rst || (r_state == S_CFG && cfg_commit)) r_cnt <= '0;
        else if (r_s2_valid && out_ready && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
    end
`endif
endmodule
